// File: rtl/masked_pkg.sv
// Shared definitions for the masked AND scheduler.
// Contents: default parameter values, the randomness-size function, the
// controller state encoding and the LFSR taps and default seed.
package masked_pkg;

  localparam int MASK_D      = 3;
  localparam int MASK_N_REQ  = 4;
  localparam int MASK_LAT    = 3;
  localparam int MASK_LFSR_W = 16;

  // x^16 + x^14 + x^13 + x^11 + 1 as a right-shifting Fibonacci register:
  // the new MSB is the XOR of state bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Fresh random bits consumed by one D-share masked AND.
  function automatic int rand_size(input int d);
    return d * (d - 1) / 2;
  endfunction

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    SETUP,
    RUN,
    CAPTURE
  } state_t;

endpackage

// File: rtl/masked_rand_lfsr.sv
// Free-running Fibonacci LFSR that supplies gadget randomness.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (state <- default seed)
//   seed_load   - load seed this cycle instead of advancing
//   seed        - new seed; all-zero is replaced by the default seed
//   state       - low OUT_W bits of the register
module masked_rand_lfsr
  import masked_pkg::*;
#(
  parameter int LFSR_W = MASK_LFSR_W,
  parameter int OUT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [OUT_W-1:0]  state
);

  localparam logic [LFSR_W-1:0] TAPS     = LFSR_TAPS[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] DEF_SEED = LFSR_DEFAULT_SEED[LFSR_W-1:0];

  logic [LFSR_W-1:0] lfsr_q;
  logic              fb;

  assign fb    = ^(lfsr_q & TAPS);
  assign state = lfsr_q[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= DEF_SEED;
    end else if (seed_load) begin
      // The all-zero state would lock the register up.
      lfsr_q <= (seed == '0) ? DEF_SEED : seed;
    end else begin
      lfsr_q <= {fb, lfsr_q[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/masked_and_scheduler.sv
// Time-shares one D-share masked AND gadget among N_REQ requesters.
// Round-robin arbitration, operand muxing, fresh randomness per operation,
// gadget enable sequencing, result capture and acknowledge, plus a flush of
// the gadget's unresettable done-counter after every reset.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   seed_load, seed    - LFSR seed load
//   req, a_sh, b_sh    - per-requester request and operand shares (D bits each)
//   ack, res           - one-cycle acknowledge and result shares
//   busy, err          - not-idle flag, sticky done-timing error
//   and_enable, and_ina, and_inb, and_rin - gadget drive
//   and_done, and_out  - gadget done level and result shares
module masked_and_scheduler
  import masked_pkg::*;
#(
  parameter int  D         = MASK_D,
  parameter int  N_REQ     = MASK_N_REQ,
  parameter int  LAT       = MASK_LAT,
  parameter int  LFSR_W    = MASK_LFSR_W,
  localparam int RAND_SIZE = rand_size(D)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*D-1:0]   a_sh,
  input  logic [N_REQ*D-1:0]   b_sh,
  output logic [N_REQ-1:0]     ack,
  output logic [D-1:0]         res,
  output logic                 busy,
  output logic                 err,
  output logic                 and_enable,
  output logic [D-1:0]         and_ina,
  output logic [D-1:0]         and_inb,
  output logic [RAND_SIZE-1:0] and_rin,
  input  logic                 and_done,
  input  logic [D-1:0]         and_out
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LAT + 2);

  state_t                 state;
  logic [IDX_W-1:0]       rr;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       pick;
  logic                   pick_vld;
  logic [CNT_W-1:0]       cnt;
  logic                   en_q;
  logic                   flush_stop;
  logic [RAND_SIZE-1:0]   rand_bits;
  logic [D-1:0]           a_vec [N_REQ];
  logic [D-1:0]           b_vec [N_REQ];

  masked_rand_lfsr #(
    .LFSR_W(LFSR_W),
    .OUT_W (RAND_SIZE)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .seed_load(seed_load),
    .seed     (seed),
    .state    (rand_bits)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_vec[i] = a_sh[i*D +: D];
      b_vec[i] = b_sh[i*D +: D];
    end
  end

  // Lowest requesting index at or after the round-robin pointer.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(rr) + k) % N_REQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // FLUSH ends in the cycle done is seen (after at least one enabled edge) or
  // once LAT+1 edges have gone by. The enable is dropped in that same cycle,
  // otherwise the closing edge would advance the gadget counter past zero.
  assign flush_stop = (state == FLUSH) && (cnt != '0) &&
                      (and_done || (cnt == CNT_W'(LAT + 1)));
  assign and_enable = en_q & ~flush_stop;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FLUSH;
      en_q    <= 1'b0;
      and_ina <= '0;
      and_inb <= '0;
      and_rin <= '0;
      res     <= '0;
      ack     <= '0;
      err     <= 1'b0;
      rr      <= '0;
      grant   <= '0;
      cnt     <= '0;
    end else begin
      ack <= '0;
      unique case (state)
        FLUSH: begin
          if (flush_stop) begin
            en_q  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
            if (!and_done) err <= 1'b1;
          end else begin
            en_q    <= 1'b1;
            and_ina <= '0;
            and_inb <= '0;
            and_rin <= rand_bits;
            if (and_enable) cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (pick_vld) begin
            grant <= pick;
            state <= SETUP;
          end
        end
        SETUP: begin
          and_ina <= a_vec[grant];
          and_inb <= b_vec[grant];
          and_rin <= rand_bits;
          en_q    <= 1'b1;
          cnt     <= '0;
          state   <= RUN;
        end
        RUN: begin
          if (cnt == CNT_W'(LAT - 1)) begin
            en_q  <= 1'b0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          // The result is taken even on a missing done so the requester is
          // never left hanging; the timing fault is recorded in err.
          res        <= and_out;
          if (!and_done) err <= 1'b1;
          ack[grant] <= 1'b1;
          rr         <= (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
          state      <= IDLE;
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_masked_and_scheduler.sv
// Self-checking bench for masked_and_scheduler: a behavioural masked AND
// gadget with a free-running, unresettable done-counter, an arithmetic
// reference of the randomness LFSR, and directed plus randomized operations.
module tb_masked_and_scheduler;
  import masked_pkg::*;

  localparam int D      = 3;
  localparam int N_REQ  = 4;
  localparam int LAT    = 3;
  localparam int LFSR_W = 16;
  localparam int RS     = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                seed_load;
  logic [LFSR_W-1:0]   seed;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*D-1:0]  a_sh;
  logic [N_REQ*D-1:0]  b_sh;
  logic [N_REQ-1:0]    ack;
  logic [D-1:0]        res;
  logic                busy;
  logic                err;
  logic                and_enable;
  logic [D-1:0]        and_ina;
  logic [D-1:0]        and_inb;
  logic [RS-1:0]       and_rin;
  logic                and_done;
  logic [D-1:0]        and_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  masked_and_scheduler #(
    .D(D), .N_REQ(N_REQ), .LAT(LAT), .LFSR_W(LFSR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .req(req), .a_sh(a_sh), .b_sh(b_sh), .ack(ack), .res(res),
    .busy(busy), .err(err), .and_enable(and_enable), .and_ina(and_ina),
    .and_inb(and_inb), .and_rin(and_rin), .and_done(and_done), .and_out(and_out)
  );

  // Gadget: counts enabled edges modulo LAT, never reset; done is a level
  // that only changes on enabled edges. 'stuck' forces done low.
  int         gcnt  = 0;
  logic       gdone = 1'b0;
  logic [D-1:0] gout = '0;
  logic       stuck = 1'b0;

  assign and_done = gdone & ~stuck;
  assign and_out  = gout;

  always @(posedge clk) begin
    if (and_enable) begin
      if (gcnt == LAT - 1) begin
        gcnt  <= 0;
        gdone <= 1'b1;
        gout  <= {(^and_ina & ^and_inb) ^ and_rin[0] ^ and_rin[1], and_rin[1], and_rin[0]};
      end else begin
        gcnt  <= gcnt + 1;
        gdone <= 1'b0;
      end
    end
  end

  // Reference LFSR written as shift/XOR arithmetic on the polynomial.
  logic [15:0] lfsr_m;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] b;
    b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1;
    return (s >> 1) | (b << 15);
  endfunction

  always @(posedge clk) begin
    if (!rst_n)         lfsr_m <= 16'hACE1;
    else if (seed_load) lfsr_m <= (seed == 16'h0) ? 16'hACE1 : seed;
    else                lfsr_m <= lfsr_next(lfsr_m);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_res"}, 32'(res), 0);
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_en"}, 32'(and_enable), 0);
    check({tag, "_ina"}, 32'(and_ina), 0);
    check({tag, "_inb"}, 32'(and_inb), 0);
    check({tag, "_rin"}, 32'(and_rin), 0);
  endtask

  // Waits for busy to fall, returning the number of enabled cycles seen and
  // the number of acks observed meanwhile.
  task automatic wait_flush(input string tag, output int en, output int acks);
    int n;
    n = 0; en = 0; acks = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
      if (and_enable) en++;
      if (ack != '0) acks++;
    end
    check({tag, "_flush_timeout"}, 32'(busy), 0);
  endtask

  // One operation by a single requester; entered at a negedge with the DUT idle.
  task automatic run_op(input int idx, input logic [2:0] a, input logic [2:0] b,
                        input int seed_mode);
    int n; int en; bit seen; logic [RS-1:0] exp_rin;
    n = 0; en = 0; seen = 0; exp_rin = '0;
    a_sh[idx*D +: D] = a;
    b_sh[idx*D +: D] = b;
    req[idx] = 1'b1;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seed_load = 1'b0;
      if (n == 1) exp_rin = lfsr_m[RS-1:0];
      if (seed_mode != 0 && n == 3) begin
        seed_load = 1'b1;
        seed = (seed_mode == 1) ? 16'($urandom) : 16'h0;
      end
      if (and_enable) begin
        en++;
        check("run_ina", 32'(and_ina), 32'(a));
        check("run_inb", 32'(and_inb), 32'(b));
        check("run_rin", 32'(and_rin), 32'(exp_rin));
      end
      if (ack != '0) seen = 1;
    end
    seed_load = 1'b0;
    req[idx] = 1'b0;
    check("op_latency", 32'(n), 32'(LAT + 3));
    check("op_ack", 32'(ack), 32'(1) << idx);
    check("op_xor_res", 32'(^res), 32'(^a & ^b));
    check("op_enabled_cycles", 32'(en), 32'(LAT));
    @(negedge clk);
    check("op_ack_pulse", 32'(ack), 0);
    check("op_idle", 32'(busy), 0);
  endtask

  initial begin
    int en; int acks; int n; int prev; int idx; bit seen;
    logic [2:0] ra; logic [2:0] rb;

    rst_n = 1'b0; seed_load = 1'b0; seed = '0; req = '0; a_sh = '0; b_sh = '0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Power-up flush: gadget counter at 0 needs LAT enabled edges.
    wait_flush("init", en, acks);
    check("init_flush_edges", 32'(en), 32'(LAT));
    check("init_err", 32'(err), 0);

    // Round-robin with all requesters pending.
    for (int i = 0; i < N_REQ; i++) begin
      a_sh[i*D +: D] = 3'($urandom);
      b_sh[i*D +: D] = 3'($urandom);
    end
    req = '1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0; seen = 0;
      while (!seen && n < 20) begin
        @(negedge clk);
        n++;
        if (k > 0 && n == 1) req[prev] = 1'b1;
        if (ack != '0) seen = 1;
      end
      idx = k % N_REQ;
      check("rr_spacing", 32'(n), 32'(LAT + 3));
      check("rr_ack", 32'(ack), 32'(1) << idx);
      check("rr_res", 32'(^res), 32'(^a_sh[idx*D +: D] & ^b_sh[idx*D +: D]));
      req[idx] = 1'b0;
      if (k == 4) req = '0;
      prev = idx;
    end
    @(negedge clk);
    check("rr_idle", 32'(busy), 0);

    // Directed results.
    run_op(1, 3'b100, 3'b011, 0);
    run_op(1, 3'b111, 3'b001, 0);

    // Randomized operations, with seed loads landing mid-operation.
    for (int k = 0; k < 8; k++) begin
      ra = 3'($urandom);
      rb = 3'($urandom);
      run_op(int'($urandom_range(0, N_REQ - 1)), ra, rb, (k == 3) ? 1 : ((k == 5) ? 2 : 0));
    end

    // Reset in the middle of RUN: two enabled edges reached the gadget.
    a_sh[2*D +: D] = 3'b101;
    b_sh[2*D +: D] = 3'b110;
    req[2] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    check_reset_values("midrst");
    rst_n = 1'b1;
    wait_flush("midrst", en, acks);
    check("midrst_flush_edges", 32'(en), 1);
    check("midrst_no_ack", 32'(acks), 0);
    check("midrst_err", 32'(err), 0);
    run_op(0, 3'b011, 3'b010, 0);

    // Gadget done stuck low during one operation.
    stuck = 1'b1;
    run_op(3, 3'b110, 3'b100, 0);
    check("stuck_err", 32'(err), 1);
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    check("stuck_err_hold", 32'(err), 1);
    run_op(2, 3'b001, 3'b111, 0);
    check("stuck_err_sticky", 32'(err), 1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("stuck_err_cleared", 32'(err), 0);
    rst_n = 1'b1;
    wait_flush("final", en, acks);
    check("final_flush_edges", 32'(en), 32'(LAT));
    check("final_err", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
